nes_controller_reader: RTL

//   Polls a serial NES-style game controller and presents debounced, active-high button levels

---
 rtl/nes_controller_reader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/nes_controller_reader.sv
// Serial NES controller poller: latch/pulse sequencing, 2-flop data sync, registered button levels
// and press pulses. Optional `NES_DEBOUNCE_EN requires two matching polls before a button changes.
module nes_controller_reader #(
  parameter int HALF_CYCLES = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       poll_start,
  input  logic       data_in,
  output logic       latch,
  output logic       pulse,
  output logic       busy,
  output logic       valid,
  output logic [7:0] buttons,
  output logic [7:0] press_pulse,
  output logic       button_up,
  output logic       button_down,
  output logic       button_left,
  output logic       button_right
);

  localparam int CW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [CW-1:0] PH_LAST = CW'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_PULSE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ph_cnt_q, ph_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      sync_q;
  logic            latch_q, latch_d;
  logic            pulse_q, pulse_d;
  logic            valid_q, valid_d;
  logic [7:0]      buttons_q, buttons_d;
  logic [7:0]      press_q, press_d;
  logic [7:0]      raw_new;
  logic [7:0]      btn_new;
  logic            phase_end;

`ifdef NES_DEBOUNCE_EN
  logic [7:0]      raw_prev_q, raw_prev_d;
`endif

  assign phase_end = (ph_cnt_q == PH_LAST);
  // Raw levels including the bit being sampled this cycle, so buttons load together with valid.
  assign raw_new   = ~shift_d;

`ifdef NES_DEBOUNCE_EN
  assign btn_new = (raw_new & ~(raw_new ^ raw_prev_q)) | (buttons_q & (raw_new ^ raw_prev_q));
`else
  assign btn_new = raw_new;
`endif

  always_comb begin
    state_d   = state_q;
    ph_cnt_d  = ph_cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    buttons_d = buttons_q;
    press_d   = '0;
`ifdef NES_DEBOUNCE_EN
    raw_prev_d = raw_prev_q;
`endif
    case (state_q)
      S_IDLE: begin
        ph_cnt_d = '0;
        if (poll_start) begin
          state_d   = S_LATCH;
          bit_idx_d = 3'd0;
        end
      end
      S_LATCH: begin
        if (phase_end) begin
          state_d  = S_LOW;
          ph_cnt_d = '0;
        end
      end
      S_LOW: begin
        if (phase_end) begin
          ph_cnt_d           = '0;
          shift_d[bit_idx_q] = sync_q[1];
          if (bit_idx_q == 3'd7) begin
            state_d   = S_DONE;
            valid_d   = 1'b1;
            buttons_d = btn_new;
            press_d   = btn_new & ~buttons_q;
`ifdef NES_DEBOUNCE_EN
            raw_prev_d = raw_new;
`endif
          end else begin
            state_d = S_PULSE;
          end
        end
      end
      S_PULSE: begin
        if (phase_end) begin
          ph_cnt_d  = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          state_d   = S_LOW;
        end
      end
      S_DONE: begin
        ph_cnt_d = '0;
        state_d  = S_IDLE;
      end
      default: begin
        ph_cnt_d = '0;
        state_d  = S_IDLE;
      end
    endcase
    latch_d = (state_d == S_LATCH);
    pulse_d = (state_d == S_PULSE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ph_cnt_q  <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'hFF;
      sync_q    <= 2'b11;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      valid_q   <= 1'b0;
      buttons_q <= '0;
      press_q   <= '0;
    end else begin
      state_q   <= state_d;
      ph_cnt_q  <= ph_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      sync_q    <= {sync_q[0], data_in};
      latch_q   <= latch_d;
      pulse_q   <= pulse_d;
      valid_q   <= valid_d;
      buttons_q <= buttons_d;
      press_q   <= press_d;
    end
  end

`ifdef NES_DEBOUNCE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) raw_prev_q <= '0;
    else       raw_prev_q <= raw_prev_d;
  end
`endif

  assign latch        = latch_q;
  assign pulse        = pulse_q;
  assign busy         = (state_q != S_IDLE);
  assign valid        = valid_q;
  assign buttons      = buttons_q;
  assign press_pulse  = press_q;
  assign button_up    = buttons_q[4];
  assign button_down  = buttons_q[5];
  assign button_left  = buttons_q[6];
  assign button_right = buttons_q[7];

endmodule
